usr_ctrl: RTL

USR_CTRL -- requirements
Module: usr_ctrl

---
 rtl/usr_pkg.sv | 42 ++++
 rtl/usr_step_cnt.sv | 44 ++++
 rtl/usr_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// ----------------------------------------------------------------------------
// usr_pkg
//   Shared definitions for the universal-shift-register controller: command
//   opcodes, register mode (select) encodings, FSM state encoding, step
//   counter width and small opcode classification helpers.
// ----------------------------------------------------------------------------
package usr_pkg;

    // Command opcodes; 5-7 are illegal and complete with err.
    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHDN = 3'd1;
    localparam logic [2:0] OP_SHUP = 3'd2;
    localparam logic [2:0] OP_RODN = 3'd3;
    localparam logic [2:0] OP_ROUP = 3'd4;

    // Register mode encodings driven on select.
    localparam logic [1:0] SEL_HOLD = 2'b00;  // hold
    localparam logic [1:0] SEL_DN   = 2'b01;  // shift toward A[0], SL enters A[3]
    localparam logic [1:0] SEL_UP   = 2'b10;  // shift toward A[3], SR enters A[0]
    localparam logic [1:0] SEL_LOAD = 2'b11;  // parallel load from I

    // Step counter width and its unit decrement.
    localparam int              CNT_W   = 3;
    localparam logic [CNT_W-1:0] CNT_ONE = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_ROUP);
    endfunction

    // True for opcodes that move data toward A[0].
    function automatic logic op_is_dn(input logic [2:0] op);
        return (op == OP_SHDN) || (op == OP_RODN);
    endfunction

endpackage

// File: rtl/usr_step_cnt.sv
// ----------------------------------------------------------------------------
// usr_step_cnt
//   Down-counter that paces the shift/rotate phase of usr_ctrl.
//   Ports:
//     clk, rst   clock and asynchronous active-high reset
//     load       load load_val this cycle (has priority over dec)
//     load_val   value to load
//     dec        decrement by one (saturates at zero)
//     zero       counter currently holds zero
// ----------------------------------------------------------------------------
module usr_step_cnt
    import usr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/usr_ctrl.sv
// ----------------------------------------------------------------------------
// usr_ctrl
//   Command sequencer for an external 4-bit universal shift register. Accepts
//   one LOAD / shift / rotate command at a time and drives the register's mode
//   and data inputs, pulsing done (and err for illegal opcodes) on completion.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | cmd_ready=1, waiting for cmd_valid
//   LOAD   | one cycle of parallel load, I = captured data
//   SHIFT  | count cycles of shift/rotate, paced by usr_step_cnt
//   DONE   | one cycle, done=1 (err=1 if opcode was illegal)
//
//   Ports:
//     Clk, Rst        clock, asynchronous active-high reset
//     cmd_valid       command present
//     cmd_op          opcode (LOAD/SHDN/SHUP/RODN/ROUP, 5-7 illegal)
//     cmd_count       shift/rotate steps 0-7
//     cmd_data        parallel load value
//     cmd_fill        serial fill bit for SHDN/SHUP
//     A               current register contents (feedback for rotates)
//     cmd_ready       command accepted on this cycle's edge if cmd_valid=1
//     select          register mode
//     I               parallel load data
//     SR, SL          serial inputs into A[0] / A[3]
//     done, err       completion pulses
// ----------------------------------------------------------------------------
module usr_ctrl
    import usr_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_count,
    input  logic [3:0] cmd_data,
    input  logic       cmd_fill,
    input  logic [3:0] A,
    output logic       cmd_ready,
    output logic [1:0] select,
    output logic [3:0] I,
    output logic       SR,
    output logic       SL,
    output logic       done,
    output logic       err
);

    state_t     state_q, state_d;
    logic [2:0] op_q,    op_d;
    logic [3:0] data_q,  data_d;
    logic       fill_q,  fill_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] i_q,     i_d;
    logic       ready_q, ready_d;
    logic       done_q,  done_d;
    logic       err_q,   err_d;

    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    // Only the end bits of A are fed back (rotate); the middle bits are not needed.
    logic unused_a;
    assign unused_a = ^A[2:1];

    assign accept = cmd_valid & ready_q;

    // The counter is loaded with count-1 so SHIFT can leave on the zero flag
    // and still last exactly count cycles.
    assign cnt_val = cmd_count - CNT_ONE;

    usr_step_cnt u_step_cnt (
        .clk      (Clk),
        .rst      (Rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        fill_d   = fill_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    fill_d = cmd_fill;
                    if (cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (op_is_legal(cmd_op) && (cmd_count != '0)) begin
                        state_d  = ST_SHIFT;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that, once registered, they
    // line up with the state they describe.
    always_comb begin
        sel_d   = SEL_HOLD;
        i_d     = '0;
        ready_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_LOAD: begin
                sel_d = SEL_LOAD;
                i_d   = data_d;
            end
            ST_SHIFT: begin
                sel_d = op_is_dn(op_d) ? SEL_DN : SEL_UP;
            end
            ST_DONE: begin
                done_d = 1'b1;
                err_d  = ~op_is_legal(op_d);
            end
            default: begin
                sel_d = SEL_HOLD;
            end
        endcase
    end

    // cmd_ready resets to 0 and only rises on the first edge after reset
    // release, so nothing can be accepted while Rst is asserted.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            fill_q  <= 1'b0;
            sel_q   <= SEL_HOLD;
            i_q     <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            sel_q   <= sel_d;
            i_q     <= i_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Serial inputs are combinational so rotates see the live register bits.
    always_comb begin
        SL = 1'b0;
        SR = 1'b0;
        if (state_q == ST_SHIFT) begin
            case (op_q)
                OP_SHDN: SL = fill_q;
                OP_RODN: SL = A[0];
                OP_SHUP: SR = fill_q;
                OP_ROUP: SR = A[3];
                default: begin
                    SL = 1'b0;
                    SR = 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign select    = sel_q;
    assign I         = i_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
